// File: rtl/vic20_bus_sched_if.sv
// Bus bundle between the VIC-20 cycle scheduler, its CPU/video requesters and RAM port A.
// master = requester/RAM side that drives the scheduler inputs; slave = the scheduler.
interface vic20_bus_sched_if;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  ram_dout;
  logic        cpu_clken;
  logic        via1_clken;
  logic        via4_clken;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        vid_ack;
  logic        vid_valid;
  logic [7:0]  vid_data;

  modport master (
    output cpu_addr, cpu_we, cpu_dout, vid_req, vid_addr, ram_dout,
    input  cpu_clken, via1_clken, via4_clken, ram_addr, ram_din, ram_we,
           vid_ack, vid_valid, vid_data
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_dout, vid_req, vid_addr, ram_dout,
    output cpu_clken, via1_clken, via4_clken, ram_addr, ram_din, ram_we,
           vid_ack, vid_valid, vid_data
  );
endinterface

// File: rtl/vic20_bus_sched.sv
// Divides clk25 into DIV-tick CPU bus cycles and time-shares RAM port A with video fetches.
// Video data returns 2 ticks after vid_ack; requests outside the video window wait for the next one.
module vic20_bus_sched #(
  parameter int DIV       = 24,
  parameter int VID_SLOTS = 8
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic             pause,
  vic20_bus_sched_if.slave bus
);
  localparam int TW  = $clog2(DIV);
  localparam int QTR = DIV / 4;
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] T_VID  = TW'(VID_SLOTS);
  localparam logic [QW-1:0] Q_LAST = QW'(QTR - 1);

  logic [TW-1:0] t;
  logic [QW-1:0] qt;
  logic          fetch_pend;
  logic          vid_valid_q;
  logic [7:0]    vid_data_q;

  logic cyc_end;
  logic qtr_end;
  logic in_vid;
  logic grant;
  logic cpu_run;

  assign cyc_end = (t == T_LAST);
  assign qtr_end = (qt == Q_LAST);
  assign in_vid  = (t < T_VID);
  assign cpu_run = ~pause & ~reset;
  assign grant   = bus.vid_req & in_vid & ~reset;

  assign bus.cpu_clken  = cyc_end & cpu_run;
  assign bus.via1_clken = cyc_end & cpu_run;
  assign bus.via4_clken = qtr_end & cpu_run;
  assign bus.ram_we     = bus.cpu_we & cyc_end & cpu_run;
  assign bus.vid_ack    = grant;
  assign bus.ram_din    = bus.cpu_dout;
  assign bus.ram_addr   = reset ? 16'h0000 : (grant ? bus.vid_addr : bus.cpu_addr);
  assign bus.vid_valid  = vid_valid_q;
  assign bus.vid_data   = vid_data_q;

  // qt runs alongside t so the quarter strobes avoid a modulo on t; DIV is a multiple of 4
  // so both counters wrap together at the end of every bus cycle.
  always_ff @(posedge clk25) begin
    if (reset) begin
      t           <= '0;
      qt          <= '0;
      fetch_pend  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 8'h00;
    end else begin
      t           <= cyc_end ? '0 : t + 1'b1;
      qt          <= qtr_end ? '0 : qt + 1'b1;
      fetch_pend  <= grant;
      vid_valid_q <= fetch_pend;
      if (fetch_pend) begin
        vid_data_q <= bus.ram_dout;
      end
    end
  end

  a_no_write_in_vid: assert property (@(posedge clk25) disable iff (reset)
    !(bus.ram_we && in_vid));
  a_ack_in_window: assert property (@(posedge clk25)
    bus.vid_ack |-> in_vid);
endmodule

// File: tb/tb_vic20_bus_sched.sv
// Bench for vic20_bus_sched: directed table, hand-written corner sequences and a random run
// checked against a tick/queue reference model and a read-first RAM model.
module tb_vic20_bus_sched;
  localparam int DIV = 24;
  localparam int VS  = 8;
  localparam int QTR = DIV / 4;

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;

  vic20_bus_sched_if bus();

  vic20_bus_sched #(.DIV(DIV), .VID_SLOTS(VS)) dut (
    .clk25 (clk25),
    .reset (reset),
    .pause (pause),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int n_pass  = 0;
  int n_total = 0;
  int n       = 0;
  logic [7:0] mem [65536];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
    n++;
  endtask

  task automatic go_to(input int k);
    while (n < k) step();
  endtask

  // RAM port A: synchronous read-first, address/strobe sampled mid-tick
  logic [15:0] rq_addr;
  logic        rq_we;
  logic [7:0]  rq_din;
  initial begin
    bus.ram_dout = 8'h00;
    forever begin
      @(negedge clk25);
      rq_addr = bus.ram_addr;
      rq_we   = bus.ram_we;
      rq_din  = bus.ram_din;
      @(posedge clk25);
      #1;
      bus.ram_dout = mem[rq_addr];
      if (rq_we) mem[rq_addr] = rq_din;
    end
  end

  // Reference model: bus-cycle position plus a queue of fetches due back at grant+2
  typedef struct { int due; logic [7:0] dat; } ret_t;
  ret_t ret_q[$];
  int   cyc = 0;
  int   t_m = 0;
  bit   rst_held = 0;
  logic en_e, v4_e, ack_e, we_e, valid_e;
  logic [15:0] addr_e;

  initial begin
    forever begin
      @(negedge clk25);
      if (reset) begin
        if (rst_held)
          chk("rst_outputs", {bus.cpu_clken, bus.via1_clken, bus.via4_clken, bus.ram_we,
                              bus.vid_ack, bus.vid_valid, bus.vid_data, bus.ram_addr}, 64'd0);
        rst_held = 1;
        t_m = 0;
        ret_q.delete();
      end else begin
        rst_held = 0;
        en_e   = (t_m == DIV - 1) && !pause;
        v4_e   = (t_m % QTR == QTR - 1) && !pause;
        ack_e  = bus.vid_req && (t_m < VS);
        we_e   = bus.cpu_we && en_e;
        addr_e = ack_e ? bus.vid_addr : bus.cpu_addr;
        chk("cpu_clken", bus.cpu_clken, en_e);
        chk("via1_clken", bus.via1_clken, en_e);
        chk("via4_clken", bus.via4_clken, v4_e);
        chk("ram_we", bus.ram_we, we_e);
        chk("vid_ack", bus.vid_ack, ack_e);
        chk("ram_addr", bus.ram_addr, addr_e);
        chk("ram_din", bus.ram_din, bus.cpu_dout);
        valid_e = (ret_q.size() > 0) && (ret_q[0].due == cyc);
        chk("vid_valid", bus.vid_valid, valid_e);
        if (valid_e) begin
          chk("vid_data", bus.vid_data, ret_q[0].dat);
          void'(ret_q.pop_front());
        end
        if (ack_e) ret_q.push_back('{cyc + 2, mem[bus.vid_addr]});
        t_m = (t_m + 1) % DIV;
      end
      cyc++;
    end
  end

  typedef struct {
    int          tick;
    logic        clken;
    logic        via4;
    logic        we;
    logic [15:0] addr;
  } vec_t;
  vec_t tbl[12];

  int   cnt_a, cnt_b, cnt_c, first_k;
  logic last_ack;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
    bus.cpu_addr = 16'h1000;
    bus.cpu_we   = 1'b1;
    bus.cpu_dout = 8'hA5;
    bus.vid_req  = 1'b0;
    bus.vid_addr = 16'h0000;

    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 16'h1000};
    tbl[1]  = '{5,  1'b0, 1'b1, 1'b0, 16'h1000};
    tbl[2]  = '{6,  1'b0, 1'b0, 1'b0, 16'h1000};
    tbl[3]  = '{11, 1'b0, 1'b1, 1'b0, 16'h1000};
    tbl[4]  = '{17, 1'b0, 1'b1, 1'b0, 16'h1000};
    tbl[5]  = '{22, 1'b0, 1'b0, 1'b0, 16'h1000};
    tbl[6]  = '{23, 1'b1, 1'b1, 1'b1, 16'h1000};
    tbl[7]  = '{24, 1'b0, 1'b0, 1'b0, 16'h1000};
    tbl[8]  = '{29, 1'b0, 1'b1, 1'b0, 16'h1000};
    tbl[9]  = '{47, 1'b1, 1'b1, 1'b1, 16'h1000};
    tbl[10] = '{48, 1'b0, 1'b0, 1'b0, 16'h1000};
    tbl[11] = '{71, 1'b1, 1'b1, 1'b1, 16'h1000};

    // reset 3 ticks; the tick after release is t=0
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b0;
    n = 0;

    for (int i = 0; i < 12; i++) begin
      go_to(tbl[i].tick);
      @(negedge clk25);
      chk($sformatf("tbl[%0d]", i),
          {bus.cpu_clken, bus.via1_clken, bus.via4_clken, bus.ram_we, bus.vid_ack,
           bus.ram_addr, bus.ram_din},
          {tbl[i].clken, tbl[i].clken, tbl[i].via4, tbl[i].we, 1'b0, tbl[i].addr, 8'hA5});
    end

    // one write strobe per bus cycle
    go_to(72);
    cnt_a = 0;
    for (int k = 0; k < DIV; k++) begin
      @(negedge clk25);
      if (bus.ram_we) cnt_a++;
      step();
    end
    chk("we_per_cycle", cnt_a, 1);

    // video burst held from t=0 with a moving address
    bus.cpu_we  = 1'b0;
    bus.vid_req = 1'b1;
    for (int k = 0; k < DIV; k++) begin
      bus.vid_addr = 16'h1E00 + 16'(k);
      @(negedge clk25);
      chk("burst_ack", bus.vid_ack, (k < VS));
      if (k >= 2 && k <= VS + 1) begin
        chk("burst_valid", bus.vid_valid, 1'b1);
        chk("burst_data", bus.vid_data, mem[16'h1E00 + 16'(k - 2)]);
      end else begin
        chk("burst_valid", bus.vid_valid, 1'b0);
      end
      step();
    end
    bus.vid_req = 1'b0;

    // request raised in the CPU window waits for the next video window
    go_to(132);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h1E20;
    for (int k = 12; k < DIV; k++) begin
      @(negedge clk25);
      chk("late_noack", bus.vid_ack, 1'b0);
      step();
    end
    @(negedge clk25);
    chk("late_ack_t0", bus.vid_ack, 1'b1);
    step();
    bus.vid_req = 1'b0;
    @(negedge clk25);
    chk("late_valid_t1", bus.vid_valid, 1'b0);
    step();
    @(negedge clk25);
    chk("late_valid_t2", bus.vid_valid, 1'b1);
    chk("late_data_t2", bus.vid_data, mem[16'h1E20]);
    step();

    // two paused bus cycles with video active
    go_to(168);
    pause        = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h1E40;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk25);
      if (bus.cpu_clken || bus.via1_clken || bus.via4_clken || bus.ram_we) cnt_a++;
      if (bus.vid_ack) cnt_b++;
      if (bus.vid_valid) cnt_c++;
      step();
    end
    chk("pause_no_enables", cnt_a, 0);
    chk("pause_acks", cnt_b, 2 * VS);
    chk("pause_valids", cnt_c, 2 * VS);
    pause       = 1'b0;
    bus.vid_req = 1'b0;
    first_k = -1;
    cnt_a = 0;
    for (int k = 0; k < DIV; k++) begin
      @(negedge clk25);
      if (bus.cpu_clken && first_k < 0) first_k = k;
      if (bus.ram_we) cnt_a++;
      step();
    end
    chk("resume_clken_t", first_k, DIV - 1);
    chk("resume_we_count", cnt_a, 1);

    // reset right after a grant discards the fetch
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h1E50;
    @(negedge clk25);
    chk("rst_grant_t0", bus.vid_ack, 1'b1);
    step();
    reset = 1'b1;
    @(negedge clk25);
    chk("rst_ack_gated", bus.vid_ack, 1'b0);
    chk("rst_addr_zero", bus.ram_addr, 16'h0000);
    repeat (3) @(posedge clk25);
    #1;
    reset = 1'b0;
    bus.vid_req = 1'b0;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk25);
      chk("rst_no_valid", bus.vid_valid, 1'b0);
      if (k == QTR - 1) chk("rst_t_restart", bus.via4_clken, 1'b1);
      step();
    end

    // random traffic against the reference model
    last_ack = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (n % DIV == 0) begin
        bus.cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h1E00 + 16'($urandom_range(0, 255))
                                                    : 16'($urandom);
        bus.cpu_we   = $urandom_range(0, 1) == 1;
        bus.cpu_dout = 8'($urandom);
      end
      if (last_ack || !bus.vid_req) begin
        bus.vid_req  = $urandom_range(0, 2) != 0;
        bus.vid_addr = 16'h1E00 + 16'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      @(negedge clk25);
      last_ack = bus.vid_ack;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
